uart_rx_core: RTL and testbench

- Asynchronous serial receiver for the board UART_RXD pin: 8N1 framing, LSB first, 16x oversampling with 3-sample majority vote.
- Complements the transmit path so host-to-board bytes reach user logic (e.g. the virtual-JTAG UART test core).
- Delivers each byte through a one-entry valid/ready holding register.
- Flags framing errors and overruns.

---
 rtl/uart_rx_core.sv | 171 +++++++++++++++++
 tb/tb_uart_rx_core.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 asynchronous receiver with 16x oversampling.
// Each bit is judged by a 3-sample majority vote. The received byte is
// delivered through a one-entry valid/ready holding register. Framing
// errors and overruns are reported as one-cycle pulses.
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge (or for the line to go high after a break or reset)
// START | start bit, mid-bit majority rejects glitches
// DATA  | DATA_BITS data bits, shifted in LSB first
// STOP  | stop bit, judged at mid-bit, byte delivered on the following edge
`timescale 1ns/1ps

module uart_rx_core #(
    parameter int OVS_DIV   = 27,
    parameter int DATA_BITS = 8
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(OVS_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVS_DIV - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state;
    logic                 sync_a;
    logic                 rs;
    logic [1:0]           sync_vld;
    logic [CW-1:0]        tick_cnt;
    logic                 tick;
    logic [3:0]           s;
    logic                 samp7;
    logic                 samp8;
    logic                 maj;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 stop_done;
    logic                 stop_bit;
    logic                 wait_high;

    assign tick = (tick_cnt == CNT_LAST);
    assign maj  = (samp7 & samp8) | (samp7 & rs) | (samp8 & rs);

    // Two-flop synchronizer for rxd; sync_vld marks when rs reflects the real line
    // rather than the reset value, so a line held low across reset is not
    // mistaken for a fresh start edge.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            sync_a   <= 1'b1;
            rs       <= 1'b1;
            sync_vld <= 2'b00;
        end else begin
            sync_a   <= rxd;
            rs       <= sync_a;
            sync_vld <= {sync_vld[0], 1'b1};
        end
    end

    // Receive FSM with oversample tick counter, sample counter and holding register.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            s         <= 4'd0;
            samp7     <= 1'b1;
            samp8     <= 1'b1;
            bit_idx   <= 3'd0;
            shreg     <= '0;
            stop_done <= 1'b0;
            stop_bit  <= 1'b1;
            wait_high <= 1'b1;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            if (state == IDLE) begin
                tick_cnt <= '0;
                s        <= 4'd0;
            end else if (tick) begin
                tick_cnt <= '0;
                s        <= s + 4'd1;
                if (s == 4'd7) samp7 <= rs;
                if (s == 4'd8) samp8 <= rs;
            end else begin
                tick_cnt <= tick_cnt + CW'(1);
            end

            case (state)
                IDLE: begin
                    stop_done <= 1'b0;
                    if (wait_high) begin
                        if (rs && sync_vld[1]) begin
                            wait_high <= 1'b0;
                        end
                    end else if (!rs) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        if (s == 4'd9 && maj) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else if (s == 4'd15) begin
                            state   <= DATA;
                            bit_idx <= 3'd0;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (s == 4'd9) begin
                            shreg <= {maj, shreg[DATA_BITS-1:1]};
                        end
                        if (s == 4'd15) begin
                            if (bit_idx == LAST_BIT) begin
                                state <= STOP;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end
                    end
                end
                STOP: begin
                    if (stop_done) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        stop_done <= 1'b0;
                        if (stop_bit) begin
                            if (!rx_valid || rx_ready) begin
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            wait_high <= 1'b1;
                        end
                    end else if (tick && s == 4'd9) begin
                        stop_bit  <= maj;
                        stop_done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Testbench for uart_rx_core: table-driven frames, directed corner cases,
// and randomized frames compared against a byte-level expectation queue.
`timescale 1ns/1ps

module tb_uart_rx_core;

    localparam int OVS     = 2;
    localparam int DB      = 8;
    localparam int BIT_CLK = 16 * OVS;
    localparam int LAT     = ((DB + 1) * 16 + 10) * OVS + 1;

    logic          CLK;
    logic          RSTn;
    logic          rxd;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          frame_err;
    logic          overrun;
    logic          busy;

    uart_rx_core #(.OVS_DIV(OVS), .DATA_BITS(DB)) dut (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .rxd      (rxd),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Observed events, sampled on the falling edge.
    int         cyc = 0;
    int         hs_cnt = 0;
    int         ferr_cnt = 0;
    int         ovr_cnt = 0;
    int         busy_rises = 0;
    int         busy_rise_cyc = 0;
    int         valid_rise_cyc = 0;
    int         valid_fall_cyc = 0;
    logic [7:0] hs_log [0:1023];
    logic       prev_busy = 1'b0;
    logic       prev_valid = 1'b0;

    always @(negedge CLK) begin
        cyc = cyc + 1;
        if (busy && !prev_busy) begin
            busy_rises    = busy_rises + 1;
            busy_rise_cyc = cyc;
        end
        if (rx_valid && !prev_valid) valid_rise_cyc = cyc;
        if (!rx_valid && prev_valid) valid_fall_cyc = cyc;
        if (rx_valid && rx_ready && RSTn) begin
            hs_log[hs_cnt[9:0]] = rx_data;
            hs_cnt = hs_cnt + 1;
        end
        if (frame_err) ferr_cnt = ferr_cnt + 1;
        if (overrun)   ovr_cnt  = ovr_cnt + 1;
        prev_busy  = busy;
        prev_valid = rx_valid;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) begin
            @(posedge CLK); #1;
        end
    endtask

    // Drive one frame at exactly BIT_CLK clocks per bit. glitch inverts the
    // line for the single clock that lands on the s=8 sample of each data bit.
    // rst_k >= 0 pulses RSTn low for one cycle inside frame bit rst_k.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit glitch, input int rst_k);
        logic v;
        for (int k = 0; k < DB + 2; k++) begin
            if (k == 0)           v = 1'b0;
            else if (k == DB + 1) v = stop_ok;
            else                  v = d[k-1];
            for (int j = 0; j < BIT_CLK; j++) begin
                if (rst_k == k && j == 9) begin
                    RSTn = 1'b1;
                    check("rst_rx_data", 32'(rx_data), 32'h0);
                    check("rst_rx_valid", 32'(rx_valid), 32'h0);
                    check("rst_busy", 32'(busy), 32'h0);
                    check("rst_frame_err", 32'(frame_err), 32'h0);
                    check("rst_overrun", 32'(overrun), 32'h0);
                end
                rxd = v ^ (glitch && k >= 1 && k <= DB && j == 18);
                if (rst_k == k && j == 8) RSTn = 1'b0;
                @(posedge CLK); #1;
            end
        end
        rxd = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        int         exp_hs;
        int         exp_ferr;
    } vec_t;

    vec_t       vecs [7];
    logic [7:0] exp_q [$];
    int         h0, f0, o0, b0, exp_ferr;
    int         gap;
    bit         prev_bad;
    bit         ok;
    logic [7:0] rd;

    initial begin
        vecs[0] = '{8'h00, 1'b1, 1, 0};
        vecs[1] = '{8'hFF, 1'b1, 1, 0};
        vecs[2] = '{8'h5A, 1'b1, 1, 0};
        vecs[3] = '{8'h01, 1'b1, 1, 0};
        vecs[4] = '{8'h80, 1'b1, 1, 0};
        vecs[5] = '{8'h3C, 1'b0, 0, 1};
        vecs[6] = '{8'hC9, 1'b1, 1, 0};

        // Reset state
        RSTn = 1'b0; rxd = 1'b1; rx_ready = 1'b1;
        repeat (3) begin @(posedge CLK); #1; end
        check("reset_rx_data", 32'(rx_data), 32'h0);
        check("reset_rx_valid", 32'(rx_valid), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_overrun", 32'(overrun), 32'h0);
        RSTn = 1'b1;
        idle(10);

        // Clean byte with latency and pulse width
        h0 = hs_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
        send_frame(8'hA5, 1'b1, 1'b0, -1);
        idle(40);
        check("clean_hs_count", 32'(hs_cnt - h0), 32'd1);
        check("clean_data", 32'(hs_log[h0]), 32'hA5);
        check("clean_latency", 32'(valid_rise_cyc - busy_rise_cyc), 32'(LAT));
        check("clean_valid_width", 32'(valid_fall_cyc - valid_rise_cyc), 32'd1);
        check("clean_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("clean_ovr", 32'(ovr_cnt - o0), 32'd0);

        // Table of single frames
        for (int i = 0; i < 7; i++) begin
            h0 = hs_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
            send_frame(vecs[i].data, vecs[i].stop_ok, 1'b0, -1);
            idle(40);
            check($sformatf("vec%0d_hs_count", i), 32'(hs_cnt - h0), 32'(vecs[i].exp_hs));
            if (vecs[i].exp_hs > 0)
                check($sformatf("vec%0d_data", i), 32'(hs_log[h0]), 32'(vecs[i].data));
            check($sformatf("vec%0d_ferr", i), 32'(ferr_cnt - f0), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d_ovr", i), 32'(ovr_cnt - o0), 32'd0);
        end

        // Back-to-back frames with zero idle gap
        h0 = hs_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
        send_frame(8'h00, 1'b1, 1'b0, -1);
        send_frame(8'hFF, 1'b1, 1'b0, -1);
        send_frame(8'h55, 1'b1, 1'b0, -1);
        idle(40);
        check("b2b_hs_count", 32'(hs_cnt - h0), 32'd3);
        check("b2b_data0", 32'(hs_log[h0]), 32'h00);
        check("b2b_data1", 32'(hs_log[h0+1]), 32'hFF);
        check("b2b_data2", 32'(hs_log[h0+2]), 32'h55);
        check("b2b_errors", 32'(ferr_cnt - f0 + ovr_cnt - o0), 32'd0);

        // Overrun
        rx_ready = 1'b0;
        h0 = hs_cnt; o0 = ovr_cnt;
        send_frame(8'h12, 1'b1, 1'b0, -1);
        idle(40);
        check("ovr_first_valid", 32'(rx_valid), 32'd1);
        check("ovr_first_data", 32'(rx_data), 32'h12);
        send_frame(8'h34, 1'b1, 1'b0, -1);
        idle(40);
        check("ovr_pulse", 32'(ovr_cnt - o0), 32'd1);
        check("ovr_kept_data", 32'(rx_data), 32'h12);
        check("ovr_kept_valid", 32'(rx_valid), 32'd1);
        rx_ready = 1'b1;
        @(posedge CLK); #1;
        check("ovr_valid_drop", 32'(rx_valid), 32'd0);
        check("ovr_data_held", 32'(rx_data), 32'h12);
        check("ovr_hs_count", 32'(hs_cnt - h0), 32'd1);
        check("ovr_hs_data", 32'(hs_log[h0]), 32'h12);

        // Framing error followed by a break
        h0 = hs_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, -1);
        rxd = 1'b0;
        b0 = busy_rises;
        repeat (5 * BIT_CLK) begin @(posedge CLK); #1; end
        check("break_no_retrigger", 32'(busy_rises - b0), 32'd0);
        check("break_ferr", 32'(ferr_cnt - f0), 32'd1);
        check("break_no_valid", 32'(hs_cnt - h0), 32'd0);
        idle(BIT_CLK);
        send_frame(8'h81, 1'b1, 1'b0, -1);
        idle(40);
        check("break_next_count", 32'(hs_cnt - h0), 32'd1);
        check("break_next_data", 32'(hs_log[h0]), 32'h81);

        // Short low glitch on an idle line
        h0 = hs_cnt; f0 = ferr_cnt; b0 = busy_rises;
        rxd = 1'b0;
        repeat (BIT_CLK / 4) begin @(posedge CLK); #1; end
        idle(60);
        check("glitch_started", 32'(busy_rises - b0), 32'd1);
        check("glitch_idle", 32'(busy), 32'd0);
        check("glitch_no_valid", 32'(hs_cnt - h0), 32'd0);
        check("glitch_no_ferr", 32'(ferr_cnt - f0), 32'd0);

        // Single-sample noise inside each data bit
        h0 = hs_cnt;
        send_frame(8'h6E, 1'b1, 1'b1, -1);
        idle(40);
        check("noise_count", 32'(hs_cnt - h0), 32'd1);
        check("noise_data", 32'(hs_log[h0]), 32'h6E);

        // Reset during data bit 4 (frame bit 5)
        h0 = hs_cnt; f0 = ferr_cnt; o0 = ovr_cnt; b0 = busy_rises;
        send_frame(8'hC3, 1'b1, 1'b0, 5);
        idle(64);
        check("rst_no_valid", 32'(hs_cnt - h0), 32'd0);
        check("rst_no_err", 32'(ferr_cnt - f0 + ovr_cnt - o0), 32'd0);
        check("rst_no_restart", 32'(busy_rises - b0), 32'd1);
        send_frame(8'h7E, 1'b1, 1'b0, -1);
        idle(40);
        check("rst_next_count", 32'(hs_cnt - h0), 32'd1);
        check("rst_next_data", 32'(hs_log[h0]), 32'h7E);

        // Randomized frames against a byte-level expectation
        exp_q.delete();
        exp_ferr = 0;
        prev_bad = 1'b0;
        h0 = hs_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
        for (int i = 0; i < 20; i++) begin
            rd  = 8'($urandom_range(0, 255));
            ok  = ($urandom_range(0, 7) != 0);
            gap = $urandom_range(0, 48);
            if (prev_bad && gap < 8) gap = 8;
            idle(gap);
            send_frame(rd, ok, 1'b0, -1);
            if (ok) exp_q.push_back(rd);
            else    exp_ferr = exp_ferr + 1;
            prev_bad = !ok;
        end
        idle(60);
        check("rand_hs_count", 32'(hs_cnt - h0), 32'(exp_q.size()));
        check("rand_ferr", 32'(ferr_cnt - f0), 32'(exp_ferr));
        check("rand_ovr", 32'(ovr_cnt - o0), 32'd0);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < hs_cnt - h0)
                check($sformatf("rand_data%0d", i), 32'(hs_log[h0+i]), 32'(exp_q[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
